// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pong_pkg
// Purpose : Definitions shared by the speed-select block and the ball speed
//           divider. It holds the bus width of the speed value, the three
//           selectable half-periods, the clamp floor for the ball divider,
//           and the divider run/pause mode encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Width of the half-period value passed from speed select to the divider.
  localparam int unsigned SPEED_W = 32;

  // Half-periods in system-clock cycles. A smaller value gives a faster ball.
  localparam int unsigned SPEED_FAST   = 56250;
  localparam int unsigned SPEED_NORMAL = 156250;
  localparam int unsigned SPEED_SLOW   = 256250;

  // Smallest half-period the divider accepts. It must be at least 1, so that
  // the terminal compare (period - 1) cannot wrap.
  localparam int unsigned BALL_MIN_PERIOD = 1000;

  // Divider operating mode. It follows the enable input every cycle.
  typedef enum logic [0:0] {
    MODE_PAUSE = 1'b0,
    MODE_RUN   = 1'b1
  } ball_mode_e;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/ball_speed_divider.sv
`default_nettype none
// ============================================================================
// Module  : ball_speed_divider
// Purpose : Divides clk down to the ball-movement clock. The half-period in
//           force is re-sampled from counter_val only at a half-period
//           boundary or on restart, so ball_clk never glitches.
// Ports   :
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   counter_val    in   requested half-period (clk cycles) from speed select
//   enable         in   1 = run, 0 = pause (counter and ball_clk hold)
//   restart        in   synchronous restart from phase 0 (overrides enable)
//   ball_clk       out  ball clock, toggles every active_period cycles
//   tick           out  one-cycle pulse coincident with each ball_clk rise
//   active_period  out  half-period currently in force
//   period_update  out  one-cycle pulse when active_period changes value
// Revision: 1.0 - initial release
// ============================================================================
module ball_speed_divider
  import pong_pkg::*;
#(
  parameter int unsigned      WIDTH          = SPEED_W,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(SPEED_NORMAL),
  parameter logic [WIDTH-1:0] MIN_PERIOD     = WIDTH'(BALL_MIN_PERIOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] counter_val,
  input  logic             enable,
  input  logic             restart,
  output logic             ball_clk,
  output logic             tick,
  output logic [WIDTH-1:0] active_period,
  output logic             period_update
);

  // Raise any requested half-period below the floor. Because the floor is
  // at least 1, this also keeps zero out of the period register.
  function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] v);
    return (v < MIN_PERIOD) ? MIN_PERIOD : v;
  endfunction

  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             ball_q,   ball_d;
  logic             tick_q,   tick_d;
  logic             upd_q,    upd_d;

  ball_mode_e       w_mode;
  logic [WIDTH-1:0] w_sampled;
  logic             w_terminal;
  logic             w_changed;

  // The mode is a direct decode of enable. The count therefore advances on
  // the same edge that first sees enable high. This keeps the first rise at
  // edge P after reset release.
  assign w_mode     = enable ? MODE_RUN : MODE_PAUSE;
  assign w_sampled  = clamp_period(counter_val);
  assign w_changed  = (w_sampled != period_q);
  // The >= compare covers the case where cnt could ever sit beyond the
  // terminal value. It behaves like == while cnt stays in range.
  assign w_terminal = (cnt_q >= (period_q - WIDTH'(1)));

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    ball_d   = ball_q;
    tick_d   = 1'b0;
    upd_d    = 1'b0;

    if (restart) begin
      // Restart wins over a terminal count that falls in the same cycle.
      cnt_d    = '0;
      ball_d   = 1'b0;
      period_d = w_sampled;
      upd_d    = w_changed;
    end else begin
      case (w_mode)
        MODE_RUN: begin
          if (w_terminal) begin
            cnt_d    = '0;
            ball_d   = ~ball_q;
            tick_d   = ~ball_q;   // the rising half of the toggle
            period_d = w_sampled; // new speed only at a boundary
            upd_d    = w_changed;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: begin
          // Paused: hold the phase. tick and period_update keep their
          // default of 0.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= DEFAULT_PERIOD;
      ball_q   <= 1'b0;
      tick_q   <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      ball_q   <= ball_d;
      tick_q   <= tick_d;
      upd_q    <= upd_d;
    end
  end

  assign ball_clk      = ball_q;
  assign tick          = tick_q;
  assign active_period = period_q;
  assign period_update = upd_q;

endmodule : ball_speed_divider
`default_nettype wire

// File: tb/tb_ball_speed_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_ball_speed_divider
// Purpose : Directed, self-checking bench for ball_speed_divider. It uses
//           DEFAULT_PERIOD=8 and MIN_PERIOD=2. The expected values are
//           worked out by hand and indexed by rising-edge number after
//           rst_n is released.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ball_speed_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         restart;
  logic [W-1:0] counter_val;
  logic         ball_clk;
  logic         tick;
  logic [W-1:0] active_period;
  logic         period_update;

  int n_cmp = 0;
  int n_err = 0;
  int e     = 0; // rising edges since rst_n was last released

  always #5 clk = ~clk;

  ball_speed_divider #(
    .WIDTH         (W),
    .DEFAULT_PERIOD(32'd8),
    .MIN_PERIOD    (32'd2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .counter_val  (counter_val),
    .enable       (enable),
    .restart      (restart),
    .ball_clk     (ball_clk),
    .tick         (tick),
    .active_period(active_period),
    .period_update(period_update)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s @edge %0d: observed=%0d expected=%0d", tag, e, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic b, input logic t,
                         input logic u, input logic [W-1:0] ap);
    chk({tag, ".ball_clk"},      {31'd0, ball_clk},      {31'd0, b});
    chk({tag, ".tick"},          {31'd0, tick},          {31'd0, t});
    chk({tag, ".period_update"}, {31'd0, period_update}, {31'd0, u});
    chk({tag, ".active_period"}, active_period,          ap);
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic reset_dut(input logic [W-1:0] cv);
    rst_n       = 1'b0;
    restart     = 1'b0;
    enable      = 1'b1;
    counter_val = cv;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 32'd8);
    rst_n = 1'b1;
    e     = 0;
  endtask

  initial begin
    // 1) Free run at P=8: rise at 8, fall at 16, rise at 24. Ticks at 8 and 24.
    reset_dut(32'd8);
    for (int i = 1; i <= 24; i++) begin
      step();
      chk_out("s1_run", ((i / 8) % 2) == 1, (i % 16) == 8, 1'b0, 32'd8);
    end

    // 2) Speed change 8->3 mid-period. It takes effect at edge 8, and the
    //    next toggles come at edges 11 and 14.
    reset_dut(32'd8);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk_out("s2_pre", 1'b0, 1'b0, 1'b0, 32'd8);
      if (i == 3) counter_val = 32'd3;
    end
    step();
    chk_out("s2_edge8", 1'b1, 1'b1, 1'b1, 32'd3);
    for (int i = 9; i <= 14; i++) begin
      step();
      chk_out("s2_p3", (i < 11) || (i == 14), i == 14, 1'b0, 32'd3);
    end

    // 3) Clamp: 0 becomes 2 at edge 17 (an update). 1 also becomes 2, so it
    //    is not an update. The resulting ball_clk period is 4.
    counter_val = 32'd0;
    step(); chk_out("s3_e15", 1'b1, 1'b0, 1'b0, 32'd3);
    step(); chk_out("s3_e16", 1'b1, 1'b0, 1'b0, 32'd3);
    step(); chk_out("s3_e17", 1'b0, 1'b0, 1'b1, 32'd2);
    counter_val = 32'd1;
    step(); chk_out("s3_e18", 1'b0, 1'b0, 1'b0, 32'd2);
    step(); chk_out("s3_e19", 1'b1, 1'b1, 1'b0, 32'd2);
    step(); chk_out("s3_e20", 1'b1, 1'b0, 1'b0, 32'd2);
    step(); chk_out("s3_e21", 1'b0, 1'b0, 1'b0, 32'd2);
    step(); chk_out("s3_e22", 1'b0, 1'b0, 1'b0, 32'd2);
    step(); chk_out("s3_e23", 1'b1, 1'b1, 1'b0, 32'd2);

    // 4) Pause for 5 edges starting at cnt=4. The rise moves from edge 8 to
    //    edge 13 and the fall from edge 16 to edge 21.
    reset_dut(32'd8);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_out("s4_pre", 1'b0, 1'b0, 1'b0, 32'd8);
    end
    enable = 1'b0;
    for (int i = 5; i <= 9; i++) begin
      step();
      chk_out("s4_pause", 1'b0, 1'b0, 1'b0, 32'd8);
    end
    enable = 1'b1;
    for (int i = 10; i <= 12; i++) begin
      step();
      chk_out("s4_resume", 1'b0, 1'b0, 1'b0, 32'd8);
    end
    step(); chk_out("s4_rise13", 1'b1, 1'b1, 1'b0, 32'd8);
    for (int i = 14; i <= 20; i++) begin
      step();
      chk_out("s4_high", 1'b1, 1'b0, 1'b0, 32'd8);
    end
    step(); chk_out("s4_fall21", 1'b0, 1'b0, 1'b0, 32'd8);

    // 5) Restart at cnt=6 with counter_val=5. The next rise comes 5 edges
    //    later, at edge 12.
    reset_dut(32'd8);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk_out("s5_pre", 1'b0, 1'b0, 1'b0, 32'd8);
    end
    restart     = 1'b1;
    counter_val = 32'd5;
    step(); chk_out("s5_restart", 1'b0, 1'b0, 1'b1, 32'd5);
    restart = 1'b0;
    for (int i = 8; i <= 11; i++) begin
      step();
      chk_out("s5_low", 1'b0, 1'b0, 1'b0, 32'd5);
    end
    step(); chk_out("s5_rise12", 1'b1, 1'b1, 1'b0, 32'd5);
    for (int i = 13; i <= 16; i++) begin
      step();
      chk_out("s5_high", 1'b1, 1'b0, 1'b0, 32'd5);
    end
    for (int i = 17; i <= 21; i++) begin
      step();
      chk_out("s5_low2", 1'b0, 1'b0, 1'b0, 32'd5);
    end

    // Restart falls on the terminal count at edge 22. The rise is discarded
    //    and the period is the same, so there is no update.
    restart = 1'b1;
    step(); chk_out("s5_rst_term", 1'b0, 1'b0, 1'b0, 32'd5);
    restart = 1'b0;
    for (int i = 23; i <= 26; i++) begin
      step();
      chk_out("s5_low3", 1'b0, 1'b0, 1'b0, 32'd5);
    end
    step(); chk_out("s5_rise27", 1'b1, 1'b1, 1'b0, 32'd5);

    // 6) Assert rst_n while ball_clk, tick and the non-default period are
    //    all in effect. No clock edge occurs before the check.
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 1'b0, 32'd8);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ball_speed_divider
`default_nettype wire
